// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, ALU op encodings, default widths and the main opcode decoder
package mips_pkg;

    localparam int DEF_PC_WIDTH       = 10;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_REG_ADDR_WIDTH = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_to_reg;
        logic    mem_read;
        logic    mem_write;
        logic    alu_src;
        alu_op_e alu_op;
        logic    is_r;
        logic    is_beq;
        logic    is_bne;
        logic    is_j;
        logic    use_rt;
    } ctrl_t;

    // Unknown opcodes fall through with every control low, i.e. a NOP.
    function automatic ctrl_t decode(input logic [5:0] op);
        ctrl_t c;
        c           = '0;
        c.is_r      = op == OP_RTYPE;
        c.is_beq    = op == OP_BEQ;
        c.is_bne    = op == OP_BNE;
        c.is_j      = op == OP_J;
        c.mem_read  = op == OP_LW;
        c.mem_to_reg = op == OP_LW;
        c.mem_write = op == OP_SW;
        c.reg_write = c.is_r || op == OP_LW || op == OP_ADDI;
        c.alu_src   = op == OP_LW || op == OP_SW || op == OP_ADDI;
        c.alu_op    = c.is_r ? ALU_FUNCT : (c.is_beq || c.is_bne) ? ALU_SUB : ALU_ADD;
        c.use_rt    = c.is_r || op == OP_SW || c.is_beq || c.is_bne;
        return c;
    endfunction

endpackage

// File: rtl/id_decode_stage_if.sv
// id_decode_stage_if: IF/ID, EX/MEM, MEM/WB inputs and hazard/redirect/ID-EX outputs of the decode stage
//   master: pipeline side driving the decode stage; slave: the decode stage itself
interface id_decode_stage_if
    import mips_pkg::*;
#(
    parameter int PC_WIDTH       = DEF_PC_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) ();
    logic                      if_id_valid;
    logic [PC_WIDTH-1:0]       if_id_pc_plus4;
    logic [31:0]               if_id_instr;
    logic                      mem_wb_reg_write;
    logic [REG_ADDR_WIDTH-1:0] mem_wb_write_reg_addr;
    logic [DATA_WIDTH-1:0]     mem_wb_write_back_data;
    logic                      ex_mem_reg_write;
    logic                      ex_mem_mem_read;
    logic [REG_ADDR_WIDTH-1:0] ex_mem_dest;
    logic [DATA_WIDTH-1:0]     ex_mem_alu_result;
    logic                      stall;
    logic                      branch_taken;
    logic                      jump_taken;
    logic                      if_flush;
    logic [PC_WIDTH-1:0]       branch_address;
    logic [PC_WIDTH-1:0]       jump_address;
    logic                      id_ex_valid;
    logic                      id_ex_mem_to_reg;
    logic                      id_ex_mem_read;
    logic                      id_ex_mem_write;
    logic                      id_ex_alu_src;
    logic                      id_ex_reg_write;
    logic [1:0]                id_ex_alu_op;
    logic [DATA_WIDTH-1:0]     id_ex_reg1;
    logic [DATA_WIDTH-1:0]     id_ex_reg2;
    logic [DATA_WIDTH-1:0]     id_ex_imm;
    logic [REG_ADDR_WIDTH-1:0] id_ex_rs;
    logic [REG_ADDR_WIDTH-1:0] id_ex_rt;
    logic [REG_ADDR_WIDTH-1:0] id_ex_dest;
    logic [PC_WIDTH-1:0]       id_ex_pc_plus4;

    modport master (
        output if_id_valid, if_id_pc_plus4, if_id_instr,
               mem_wb_reg_write, mem_wb_write_reg_addr, mem_wb_write_back_data,
               ex_mem_reg_write, ex_mem_mem_read, ex_mem_dest, ex_mem_alu_result,
        input  stall, branch_taken, jump_taken, if_flush, branch_address, jump_address,
               id_ex_valid, id_ex_mem_to_reg, id_ex_mem_read, id_ex_mem_write, id_ex_alu_src,
               id_ex_reg_write, id_ex_alu_op, id_ex_reg1, id_ex_reg2, id_ex_imm,
               id_ex_rs, id_ex_rt, id_ex_dest, id_ex_pc_plus4
    );

    modport slave (
        input  if_id_valid, if_id_pc_plus4, if_id_instr,
               mem_wb_reg_write, mem_wb_write_reg_addr, mem_wb_write_back_data,
               ex_mem_reg_write, ex_mem_mem_read, ex_mem_dest, ex_mem_alu_result,
        output stall, branch_taken, jump_taken, if_flush, branch_address, jump_address,
               id_ex_valid, id_ex_mem_to_reg, id_ex_mem_read, id_ex_mem_write, id_ex_alu_src,
               id_ex_reg_write, id_ex_alu_op, id_ex_reg1, id_ex_reg2, id_ex_imm,
               id_ex_rs, id_ex_rt, id_ex_dest, id_ex_pc_plus4
    );

endinterface

// File: rtl/id_hazard_unit.sv
// id_hazard_unit: load-use and branch-operand stall detection plus EX/MEM forwarding to the branch comparator
//   inputs: decoded sources, ID/EX and EX/MEM destination state, register-file read data
//   outputs: stall, comparator operands cmp_a/cmp_b
module id_hazard_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      if_id_valid,
    input  logic                      is_branch,
    input  logic                      use_rt,
    input  logic [REG_ADDR_WIDTH-1:0] rs,
    input  logic [REG_ADDR_WIDTH-1:0] rt,
    input  logic                      id_ex_valid,
    input  logic                      id_ex_mem_read,
    input  logic                      id_ex_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] id_ex_dest,
    input  logic                      ex_mem_reg_write,
    input  logic                      ex_mem_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] ex_mem_dest,
    input  logic [DATA_WIDTH-1:0]     ex_mem_alu_result,
    input  logic [DATA_WIDTH-1:0]     rd1,
    input  logic [DATA_WIDTH-1:0]     rd2,
    output logic                      stall,
    output logic [DATA_WIDTH-1:0]     cmp_a,
    output logic [DATA_WIDTH-1:0]     cmp_b
);
    logic rs_ex, rt_ex, rs_mem, rt_mem, load_use, branch_hz;

    always_comb begin
        rs_ex     = id_ex_dest != '0 && id_ex_dest == rs;
        rt_ex     = id_ex_dest != '0 && id_ex_dest == rt;
        rs_mem    = ex_mem_dest != '0 && ex_mem_dest == rs;
        rt_mem    = ex_mem_dest != '0 && ex_mem_dest == rt;
        load_use  = id_ex_valid && id_ex_mem_read && (rs_ex || (use_rt && rt_ex));
        // Branches resolve here, so any producer still in EX, or a load still in MEM, must wait.
        branch_hz = is_branch && ((id_ex_valid && id_ex_reg_write && (rs_ex || rt_ex)) ||
                                  (ex_mem_reg_write && ex_mem_mem_read && (rs_mem || rt_mem)));
        stall     = if_id_valid && (load_use || branch_hz);
        cmp_a     = (ex_mem_reg_write && !ex_mem_mem_read && rs_mem) ? ex_mem_alu_result : rd1;
        cmp_b     = (ex_mem_reg_write && !ex_mem_mem_read && rt_mem) ? ex_mem_alu_result : rd2;
    end

endmodule

// File: rtl/register_file.sv
// register_file: 2**ADDR_WIDTH x DATA_WIDTH registers, one write port, two async read ports
//   reads of register 0 return 0; a same-cycle write to a read address is bypassed to that read
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2
);
    logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] regs_d, regs_q;

    always_comb begin
        regs_d = regs_q;
        if (we && waddr != '0) regs_d[waddr] = wdata;
        rdata1 = raddr1 == '0 ? '0 : (we && waddr == raddr1) ? wdata : regs_q[raddr1];
        rdata2 = raddr2 == '0 ? '0 : (we && waddr == raddr2) ? wdata : regs_q[raddr2];
    end

    always_ff @(posedge clk) regs_q <= reset ? '0 : regs_d;

endmodule

// File: rtl/id_decode_stage.sv
// id_decode_stage: MIPS decode stage with register file, hazard stalls, early branch/jump resolution and ID/EX register
//   clk, reset: clock and synchronous active-high reset; bus: id_decode_stage_if slave carrying all pipeline signals
module id_decode_stage
    import mips_pkg::*;
#(
    parameter int PC_WIDTH       = DEF_PC_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH
) (
    input logic               clk,
    input logic               reset,
    id_decode_stage_if.slave  bus
);
    typedef struct packed {
        logic                      valid;
        logic                      mem_to_reg;
        logic                      mem_read;
        logic                      mem_write;
        logic                      alu_src;
        logic                      reg_write;
        logic [1:0]                alu_op;
        logic [DATA_WIDTH-1:0]     reg1;
        logic [DATA_WIDTH-1:0]     reg2;
        logic [DATA_WIDTH-1:0]     imm;
        logic [REG_ADDR_WIDTH-1:0] rs;
        logic [REG_ADDR_WIDTH-1:0] rt;
        logic [REG_ADDR_WIDTH-1:0] dest;
        logic [PC_WIDTH-1:0]       pc_plus4;
    } id_ex_t;

    ctrl_t                     ctrl;
    logic [REG_ADDR_WIDTH-1:0] rs, rt, dest;
    logic [DATA_WIDTH-1:0]     imm, rd1, rd2, cmp_a, cmp_b;
    logic                      stall, equal, issue;
    id_ex_t                    id_ex_d, id_ex_q;

    register_file #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(REG_ADDR_WIDTH)) u_rf (
        .clk(clk), .reset(reset),
        .we(bus.mem_wb_reg_write), .waddr(bus.mem_wb_write_reg_addr), .wdata(bus.mem_wb_write_back_data),
        .raddr1(rs), .raddr2(rt), .rdata1(rd1), .rdata2(rd2)
    );

    id_hazard_unit #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_hz (
        .if_id_valid(bus.if_id_valid), .is_branch(ctrl.is_beq || ctrl.is_bne), .use_rt(ctrl.use_rt),
        .rs(rs), .rt(rt),
        .id_ex_valid(id_ex_q.valid), .id_ex_mem_read(id_ex_q.mem_read),
        .id_ex_reg_write(id_ex_q.reg_write), .id_ex_dest(id_ex_q.dest),
        .ex_mem_reg_write(bus.ex_mem_reg_write), .ex_mem_mem_read(bus.ex_mem_mem_read),
        .ex_mem_dest(bus.ex_mem_dest), .ex_mem_alu_result(bus.ex_mem_alu_result),
        .rd1(rd1), .rd2(rd2), .stall(stall), .cmp_a(cmp_a), .cmp_b(cmp_b)
    );

    always_comb begin
        ctrl    = decode(bus.if_id_instr[31:26]);
        rs      = REG_ADDR_WIDTH'(bus.if_id_instr[25:21]);
        rt      = REG_ADDR_WIDTH'(bus.if_id_instr[20:16]);
        dest    = ctrl.is_r ? REG_ADDR_WIDTH'(bus.if_id_instr[15:11]) : rt;
        imm     = {{(DATA_WIDTH-16){bus.if_id_instr[15]}}, bus.if_id_instr[15:0]};
        equal   = cmp_a == cmp_b;
        issue   = bus.if_id_valid && !stall;
        id_ex_d = issue ? id_ex_t'{valid: 1'b1, mem_to_reg: ctrl.mem_to_reg, mem_read: ctrl.mem_read,
                                   mem_write: ctrl.mem_write, alu_src: ctrl.alu_src,
                                   reg_write: ctrl.reg_write, alu_op: ctrl.alu_op,
                                   reg1: rd1, reg2: rd2, imm: imm, rs: rs, rt: rt, dest: dest,
                                   pc_plus4: bus.if_id_pc_plus4} : '0;
    end

    always_ff @(posedge clk) id_ex_q <= reset ? '0 : id_ex_d;

    assign bus.stall          = stall;
    assign bus.branch_taken   = issue && ((ctrl.is_beq && equal) || (ctrl.is_bne && !equal));
    assign bus.jump_taken     = issue && ctrl.is_j;
    assign bus.if_flush       = bus.branch_taken || bus.jump_taken;
    // The offset is shifted and truncated to PC width, so the sum wraps modulo 2**PC_WIDTH.
    assign bus.branch_address = bus.if_id_pc_plus4 + {imm[PC_WIDTH-3:0], 2'b00};
    assign bus.jump_address   = {bus.if_id_instr[PC_WIDTH-3:0], 2'b00};

    assign bus.id_ex_valid      = id_ex_q.valid;
    assign bus.id_ex_mem_to_reg = id_ex_q.mem_to_reg;
    assign bus.id_ex_mem_read   = id_ex_q.mem_read;
    assign bus.id_ex_mem_write  = id_ex_q.mem_write;
    assign bus.id_ex_alu_src    = id_ex_q.alu_src;
    assign bus.id_ex_reg_write  = id_ex_q.reg_write;
    assign bus.id_ex_alu_op     = id_ex_q.alu_op;
    assign bus.id_ex_reg1       = id_ex_q.reg1;
    assign bus.id_ex_reg2       = id_ex_q.reg2;
    assign bus.id_ex_imm        = id_ex_q.imm;
    assign bus.id_ex_rs         = id_ex_q.rs;
    assign bus.id_ex_rt         = id_ex_q.rt;
    assign bus.id_ex_dest       = id_ex_q.dest;
    assign bus.id_ex_pc_plus4   = id_ex_q.pc_plus4;

endmodule

// File: tb/tb_id_decode_stage.sv
// tb_id_decode_stage: directed checks of decode, hazards, forwarding, redirects and reset of id_decode_stage
module tb_id_decode_stage;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   vecs = 0;
    int   miscmp = 0;

    always #5 clk = ~clk;

    id_decode_stage_if bus ();

    id_decode_stage dut (.clk(clk), .reset(reset), .bus(bus.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [9:0] pc);
        bus.if_id_valid    = v;
        bus.if_id_instr    = ins;
        bus.if_id_pc_plus4 = pc;
        #2;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        bus.mem_wb_reg_write       = 1'b1;
        bus.mem_wb_write_reg_addr  = a;
        bus.mem_wb_write_back_data = d;
        tick();
        bus.mem_wb_reg_write = 1'b0;
    endtask

    function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return {OP_RTYPE, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin
        reset = 1'b1;
        bus.if_id_valid = 1'b0; bus.if_id_instr = '0; bus.if_id_pc_plus4 = '0;
        bus.mem_wb_reg_write = 1'b0; bus.mem_wb_write_reg_addr = '0; bus.mem_wb_write_back_data = '0;
        bus.ex_mem_reg_write = 1'b0; bus.ex_mem_mem_read = 1'b0; bus.ex_mem_dest = '0; bus.ex_mem_alu_result = '0;
        tick(); tick();
        chk("rst_valid", 32'(bus.id_ex_valid), 32'd0);
        chk("rst_reg1", bus.id_ex_reg1, 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        reset = 1'b0;
        wb(5'd1, 32'd5); wb(5'd2, 32'd7); wb(5'd7, 32'h10); wb(5'd10, 32'd9); wb(5'd11, 32'd9);

        drive(1'b1, r_add(5'd3, 5'd1, 5'd2), 10'h010);
        chk("add_stall", 32'(bus.stall), 32'd0);
        tick();
        chk("add_valid", 32'(bus.id_ex_valid), 32'd1);
        chk("add_reg1", bus.id_ex_reg1, 32'd5);
        chk("add_reg2", bus.id_ex_reg2, 32'd7);
        chk("add_dest", 32'(bus.id_ex_dest), 32'd3);
        chk("add_aluop", 32'(bus.id_ex_alu_op), 32'd2);
        chk("add_regwrite", 32'(bus.id_ex_reg_write), 32'd1);
        chk("add_pc", 32'(bus.id_ex_pc_plus4), 32'h010);

        bus.mem_wb_reg_write = 1'b1; bus.mem_wb_write_reg_addr = 5'd12; bus.mem_wb_write_back_data = 32'h55;
        drive(1'b1, r_add(5'd13, 5'd12, 5'd0), 10'h014);
        tick();
        bus.mem_wb_reg_write = 1'b0;
        chk("bypass_reg1", bus.id_ex_reg1, 32'h55);
        chk("r0_reg2", bus.id_ex_reg2, 32'd0);

        drive(1'b1, itype(OP_ADDI, 5'd1, 5'd9, 16'hFFFC), 10'h018);
        tick();
        chk("addi_dest", 32'(bus.id_ex_dest), 32'd9);
        chk("addi_imm", bus.id_ex_imm, 32'hFFFF_FFFC);
        chk("addi_alusrc", 32'(bus.id_ex_alu_src), 32'd1);
        chk("addi_aluop", 32'(bus.id_ex_alu_op), 32'd0);
        drive(1'b1, itype(OP_SW, 5'd1, 5'd2, 16'd8), 10'h01C);
        tick();
        chk("sw_memwrite", 32'(bus.id_ex_mem_write), 32'd1);
        chk("sw_regwrite", 32'(bus.id_ex_reg_write), 32'd0);
        chk("sw_reg2", bus.id_ex_reg2, 32'd7);
        drive(1'b1, {6'h3F, 26'h0}, 10'h020);
        tick();
        chk("nop_valid", 32'(bus.id_ex_valid), 32'd1);
        chk("nop_ctrl", {26'd0, bus.id_ex_reg_write, bus.id_ex_alu_src, bus.id_ex_mem_read,
                         bus.id_ex_mem_write, bus.id_ex_alu_op}, 32'd0);

        drive(1'b1, itype(OP_LW, 5'd1, 5'd4, 16'd0), 10'h024);
        tick();
        chk("lw_memread", 32'(bus.id_ex_mem_read), 32'd1);
        chk("lw_memtoreg", 32'(bus.id_ex_mem_to_reg), 32'd1);
        chk("lw_dest", 32'(bus.id_ex_dest), 32'd4);
        drive(1'b1, r_add(5'd5, 5'd4, 5'd2), 10'h028);
        chk("lu_stall", 32'(bus.stall), 32'd1);
        tick();
        chk("lu_bubble", 32'(bus.id_ex_valid), 32'd0);
        chk("lu_stall_clear", 32'(bus.stall), 32'd0);
        tick();
        chk("lu_issue_valid", 32'(bus.id_ex_valid), 32'd1);
        chk("lu_issue_dest", 32'(bus.id_ex_dest), 32'd5);

        drive(1'b1, itype(OP_BEQ, 5'd10, 5'd11, 16'd3), 10'h040);
        chk("beq_taken", 32'(bus.branch_taken), 32'd1);
        chk("beq_flush", 32'(bus.if_flush), 32'd1);
        chk("beq_addr", 32'(bus.branch_address), 32'h04C);
        chk("beq_stall", 32'(bus.stall), 32'd0);
        tick();
        chk("beq_valid", 32'(bus.id_ex_valid), 32'd1);
        chk("beq_regwrite", 32'(bus.id_ex_reg_write), 32'd0);
        drive(1'b1, itype(OP_BNE, 5'd10, 5'd11, 16'd3), 10'h044);
        chk("bne_taken", 32'(bus.branch_taken), 32'd0);
        chk("bne_flush", 32'(bus.if_flush), 32'd0);
        tick();

        bus.ex_mem_reg_write = 1'b1; bus.ex_mem_mem_read = 1'b0; bus.ex_mem_dest = 5'd6; bus.ex_mem_alu_result = 32'h10;
        drive(1'b1, itype(OP_BEQ, 5'd6, 5'd7, 16'd3), 10'h048);
        chk("fwd_stall", 32'(bus.stall), 32'd0);
        chk("fwd_taken", 32'(bus.branch_taken), 32'd1);
        tick();
        bus.ex_mem_reg_write = 1'b0; bus.ex_mem_dest = '0; bus.ex_mem_alu_result = '0;

        drive(1'b1, itype(OP_LW, 5'd1, 5'd6, 16'd0), 10'h04C);
        tick();
        drive(1'b1, itype(OP_BEQ, 5'd6, 5'd7, 16'd3), 10'h050);
        chk("lwbr_stall1", 32'(bus.stall), 32'd1);
        chk("lwbr_taken1", 32'(bus.branch_taken), 32'd0);
        tick();
        bus.ex_mem_reg_write = 1'b1; bus.ex_mem_mem_read = 1'b1; bus.ex_mem_dest = 5'd6;
        #2;
        chk("lwbr_bubble", 32'(bus.id_ex_valid), 32'd0);
        chk("lwbr_stall2", 32'(bus.stall), 32'd1);
        tick();
        bus.ex_mem_reg_write = 1'b0; bus.ex_mem_mem_read = 1'b0; bus.ex_mem_dest = '0;
        bus.mem_wb_reg_write = 1'b1; bus.mem_wb_write_reg_addr = 5'd6; bus.mem_wb_write_back_data = 32'h10;
        #2;
        chk("lwbr_stall3", 32'(bus.stall), 32'd0);
        chk("lwbr_taken3", 32'(bus.branch_taken), 32'd1);
        tick();
        bus.mem_wb_reg_write = 1'b0;

        drive(1'b1, {OP_J, 26'h3FF}, 10'h054);
        chk("j_taken", 32'(bus.jump_taken), 32'd1);
        chk("j_addr", 32'(bus.jump_address), 32'h3FC);
        chk("j_flush", 32'(bus.if_flush), 32'd1);
        chk("j_no_branch", 32'(bus.branch_taken), 32'd0);
        tick();
        drive(1'b1, itype(OP_BEQ, 5'd0, 5'd0, 16'hFFFF), 10'h000);
        chk("wrap_taken", 32'(bus.branch_taken), 32'd1);
        chk("wrap_addr", 32'(bus.branch_address), 32'h3FC);
        tick();
        drive(1'b0, {OP_J, 26'h3FF}, 10'h000);
        chk("inv_jump", 32'(bus.jump_taken), 32'd0);
        tick();
        chk("inv_bubble", 32'(bus.id_ex_valid), 32'd0);

        drive(1'b1, itype(OP_LW, 5'd1, 5'd4, 16'd0), 10'h060);
        tick();
        drive(1'b1, r_add(5'd5, 5'd4, 5'd2), 10'h064);
        chk("rs_stall", 32'(bus.stall), 32'd1);
        drive(1'b0, r_add(5'd5, 5'd4, 5'd2), 10'h064);
        chk("rs_inv_stall", 32'(bus.stall), 32'd0);
        bus.if_id_valid = 1'b1;
        reset = 1'b1;
        tick();
        chk("rs_valid", 32'(bus.id_ex_valid), 32'd0);
        chk("rs_memread", 32'(bus.id_ex_mem_read), 32'd0);
        chk("rs_dest", 32'(bus.id_ex_dest), 32'd0);
        chk("rs_reg1", bus.id_ex_reg1, 32'd0);
        reset = 1'b0;
        #2;
        chk("rs_post_stall", 32'(bus.stall), 32'd0);
        drive(1'b1, r_add(5'd5, 5'd1, 5'd2), 10'h068);
        tick();
        chk("rs_rf_reg1", bus.id_ex_reg1, 32'd0);
        chk("rs_rf_reg2", bus.id_ex_reg2, 32'd0);

        bus.mem_wb_reg_write = 1'b1; bus.mem_wb_write_reg_addr = 5'd0; bus.mem_wb_write_back_data = 32'hDEAD;
        drive(1'b1, r_add(5'd8, 5'd0, 5'd0), 10'h06C);
        tick();
        bus.mem_wb_reg_write = 1'b0;
        chk("r0_bypass", bus.id_ex_reg1, 32'd0);
        drive(1'b1, r_add(5'd8, 5'd0, 5'd0), 10'h070);
        tick();
        chk("r0_read", bus.id_ex_reg1, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule
